hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_TIMEOUT, default 64, max BUSY cycles before abort.
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 Ports SHALL be, in order:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- RS_ID  in  5  rs of instruction in ID.
- RT_ID  in  5  rt of instruction in ID.
- RT_EX  in  5  rt of instruction in EX.
- MemRead_EX  in  1  EX instruction is a load.
- BranchTaken_EX  in  1  EX branch resolved taken.
- MduStart_EX  in  1  EX instruction is a multi-cycle mul/div.
- MduDone  in  1  multi-cycle unit result valid.
- PCWrite  out  1  PC may update.
- IFIDWrite  out  1  IF/ID register may load.
- IFIDFlush  out  1  IF/ID loads a NOP.
- IDEXHold  out  1  ID/EX register keeps its contents.
- IDEXBubble  out  1  ID/EX loads all-zero control (bubble).
- EXMEMBubble  out  1  EX/MEM loads all-zero control.
- Busy  out  1  FSM in BUSY.
- MduErr  out  1  sticky timeout flag.
- StallCnt  out  CNT_W  cycles with PCWrite=0.
- FlushCnt  out  CNT_W  taken-branch flushes.

Function
REQ-004 FSM states SHALL be RUN and BUSY; outputs are combinational from state and inputs.
REQ-005 In RUN, default outputs SHALL be PCWrite=1, IFIDWrite=1, all others 0.
REQ-006 Priority in RUN SHALL be BranchTaken_EX > MduStart_EX > load-use.
REQ-007 RUN with BranchTaken_EX=1: IFIDFlush=1, IDEXBubble=1, PCWrite=1, IFIDWrite=1; remain RUN.
REQ-008 RUN with MduStart_EX=1 (no branch): PCWrite=0, IFIDWrite=0, IDEXHold=1, EXMEMBubble=1; next state BUSY.
REQ-009 Load-use SHALL be MemRead_EX=1, RT_EX!=0, and RT_EX equal to RS_ID or RT_ID.
REQ-010 RUN with load-use (no branch, no MduStart_EX): PCWrite=0, IFIDWrite=0, IDEXBubble=1 for that cycle only; remain RUN.
REQ-011 BUSY with MduDone=0: PCWrite=0, IFIDWrite=0, IDEXHold=1, EXMEMBubble=1, Busy=1.
REQ-012 BUSY with MduDone=1: RUN default outputs with Busy=1; next state RUN (release cycle, 0 extra latency).
REQ-013 A BUSY cycle counter SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-014 At count MDU_TIMEOUT-1 with MduDone=0, MduErr SHALL set (sticky), next state RUN, release outputs as REQ-012.
REQ-015 MduDone in RUN SHALL be ignored; MduStart_EX, BranchTaken_EX and load-use in BUSY SHALL be ignored.
REQ-016 StallCnt SHALL increment on every cycle with PCWrite=0, saturating at all-ones.
REQ-017 FlushCnt SHALL increment on every cycle of REQ-007, saturating at all-ones.

Reset
REQ-018 reset=1 at a rising edge SHALL force state RUN, BUSY counter 0, MduErr 0, StallCnt 0, FlushCnt 0, including mid-BUSY.
REQ-019 While reset=1, outputs SHALL be PCWrite=1, IFIDWrite=1, all others 0.

Structure
REQ-020 Shared package SHALL hold state encoding (RUN=0, BUSY=1), register-number width 5, zero-register constant.
REQ-021 One sub-module sat_counter (width param, inc, clear, value), instantiated for StallCnt and FlushCnt.

Verification
REQ-022 RT_EX=5, RS_ID=5, MemRead_EX=1 -> one cycle PCWrite=0, IDEXBubble=1; StallCnt=1.
REQ-023 RT_EX=0, RS_ID=0, MemRead_EX=1 -> no stall, PCWrite=1.
REQ-024 BranchTaken_EX=1 with simultaneous load-use -> IFIDFlush=1, IDEXBubble=1, PCWrite=1; FlushCnt=1, StallCnt=0.
REQ-025 MduStart_EX=1, MduDone after 3 BUSY cycles -> 4 stall cycles (start + 3), release on done cycle, StallCnt=4.
REQ-026 MduStart_EX=1, MduDone never, MDU_TIMEOUT=8 -> return to RUN after 8 BUSY cycles, MduErr=1 until reset.
REQ-027 reset during BUSY -> next cycle RUN, counters 0, PCWrite=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-number width and the grouped control-output bundle.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_hold;
        logic idex_bubble;
        logic exmem_bubble;
        logic busy;
    } ctl_t;

    // Free-running pipeline: PC and IF/ID advance, nothing is squashed.
    function automatic ctl_t ctl_run_default();
        ctl_t c;
        c            = '0;
        c.pc_write   = 1'b1;
        c.ifid_write = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_value <= '0;
        end else if (inc && (r_value != {W{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and a
// multi-cycle mul/div wait state with timeout, plus stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RS_ID,
    input  logic [REG_W-1:0] RT_ID,
    input  logic [REG_W-1:0] RT_EX,
    input  logic             MemRead_EX,
    input  logic             BranchTaken_EX,
    input  logic             MduStart_EX,
    input  logic             MduDone,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXHold,
    output logic             IDEXBubble,
    output logic             EXMEMBubble,
    output logic             Busy,
    output logic             MduErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int BW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [BW-1:0] TIMEOUT_LAST = BW'(MDU_TIMEOUT - 1);

    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [BW-1:0] r_busy_cnt;
    logic          r_mdu_err;
    logic          w_set_err;
    logic          w_load_use;
    logic          w_timeout;
    ctl_t          w_ctl;

    assign w_load_use = MemRead_EX && (RT_EX != ZERO_REG) &&
                        ((RT_EX == RS_ID) || (RT_EX == RT_ID));
    assign w_timeout  = (r_busy_cnt == TIMEOUT_LAST);

    always_comb begin
        w_ctl        = ctl_run_default();
        w_state_next = r_state;
        w_set_err    = 1'b0;
        if (!reset) begin
            if (r_state == ST_RUN) begin
                if (BranchTaken_EX) begin
                    w_ctl.ifid_flush  = 1'b1;
                    w_ctl.idex_bubble = 1'b1;
                end else if (MduStart_EX) begin
                    w_ctl.pc_write     = 1'b0;
                    w_ctl.ifid_write   = 1'b0;
                    w_ctl.idex_hold    = 1'b1;
                    w_ctl.exmem_bubble = 1'b1;
                    w_state_next       = ST_BUSY;
                end else if (w_load_use) begin
                    w_ctl.pc_write    = 1'b0;
                    w_ctl.ifid_write  = 1'b0;
                    w_ctl.idex_bubble = 1'b1;
                end
            end else begin
                // Done and timeout both release with zero extra latency.
                w_ctl.busy = 1'b1;
                if (MduDone) begin
                    w_state_next = ST_RUN;
                end else if (w_timeout) begin
                    w_state_next = ST_RUN;
                    w_set_err    = 1'b1;
                end else begin
                    w_ctl.pc_write     = 1'b0;
                    w_ctl.ifid_write   = 1'b0;
                    w_ctl.idex_hold    = 1'b1;
                    w_ctl.exmem_bubble = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_busy_cnt <= '0;
            r_mdu_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Held at zero while running, so it is zero on the first BUSY cycle.
            if (r_state == ST_RUN) begin
                r_busy_cnt <= '0;
            end else begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end
            if (w_set_err) begin
                r_mdu_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (!w_ctl.pc_write),
        .value (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_ctl.ifid_flush),
        .value (FlushCnt)
    );

    assign PCWrite     = w_ctl.pc_write;
    assign IFIDWrite   = w_ctl.ifid_write;
    assign IFIDFlush   = w_ctl.ifid_flush;
    assign IDEXHold    = w_ctl.idex_hold;
    assign IDEXBubble  = w_ctl.idex_bubble;
    assign EXMEMBubble = w_ctl.exmem_bubble;
    assign Busy        = w_ctl.busy;
    assign MduErr      = r_mdu_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control vectors are queued as
// stimulus is driven and compared against outputs sampled on the falling edge.
module tb_hazard_ctrl;

    localparam int TMO = 8;
    localparam int CW  = 4;

    // Control vector bit order: PCWrite IFIDWrite IFIDFlush IDEXHold IDEXBubble EXMEMBubble Busy
    localparam logic [6:0] C_RUN    = 7'b1100000;
    localparam logic [6:0] C_FLUSH  = 7'b1110100;
    localparam logic [6:0] C_LU     = 7'b0000100;
    localparam logic [6:0] C_STALL  = 7'b0001010;
    localparam logic [6:0] C_BSTALL = 7'b0001011;
    localparam logic [6:0] C_REL    = 7'b1100001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    RS_ID = '0, RT_ID = '0, RT_EX = '0;
    logic          MemRead_EX = 1'b0, BranchTaken_EX = 1'b0;
    logic          MduStart_EX = 1'b0, MduDone = 1'b0;
    logic          PCWrite, IFIDWrite, IFIDFlush, IDEXHold, IDEXBubble;
    logic          EXMEMBubble, Busy, MduErr;
    logic [CW-1:0] StallCnt, FlushCnt;
    logic [6:0]    w_obs;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] exp_ctl_q[$];
    string      exp_nm_q[$];
    logic [6:0] obs_q[$];

    hazard_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .RS_ID          (RS_ID),
        .RT_ID          (RT_ID),
        .RT_EX          (RT_EX),
        .MemRead_EX     (MemRead_EX),
        .BranchTaken_EX (BranchTaken_EX),
        .MduStart_EX    (MduStart_EX),
        .MduDone        (MduDone),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IFIDFlush      (IFIDFlush),
        .IDEXHold       (IDEXHold),
        .IDEXBubble     (IDEXBubble),
        .EXMEMBubble    (EXMEMBubble),
        .Busy           (Busy),
        .MduErr         (MduErr),
        .StallCnt       (StallCnt),
        .FlushCnt       (FlushCnt)
    );

    assign w_obs = {PCWrite, IFIDWrite, IFIDFlush, IDEXHold, IDEXBubble, EXMEMBubble, Busy};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got running want finished");
        $fatal(1, "watchdog");
    end

    // One clock cycle of stimulus; the expected vector goes on the scoreboard.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rtex,
                        input logic mr, input logic br, input logic ms, input logic dn,
                        input logic rst, input logic [6:0] e, input string nm);
        @(posedge clk);
        #1;
        RS_ID = rs; RT_ID = rt; RT_EX = rtex;
        MemRead_EX = mr; BranchTaken_EX = br; MduStart_EX = ms; MduDone = dn;
        reset = rst;
        exp_ctl_q.push_back(e);
        exp_nm_q.push_back(nm);
        @(negedge clk);
        obs_q.push_back(w_obs);
    endtask

    task automatic idle(input logic [6:0] e, input string nm);
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, nm);
    endtask

    task automatic do_reset();
        step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_RUN, "rst_outputs");
    endtask

    task automatic test_reset();
        logic [6:0] e, o;
        string nm;
        do_reset();
        idle(C_RUN, "post_reset_idle");
        while (exp_ctl_q.size() > 0) begin
            e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
            else $display("[tb] %s ctl=%b", nm, o);
        end
        n_vec++;
        if ({MduErr, StallCnt, FlushCnt} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: err/stall/flush got %b/%0d/%0d want 0/0/0", MduErr, StallCnt, FlushCnt);
        end
    endtask

    task automatic test_load_use();
        logic [6:0] e, o;
        string nm;
        do_reset();
        step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, "lu_rs");
        idle(C_RUN, "lu_rs_after");
        n_vec++;
        if (StallCnt !== 4'd1) begin n_err++; $display("FAIL lu_stallcnt1: got %0d want 1", StallCnt); end
        step(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,  "lu_rt");
        step(5'd3, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "no_memread");
        step(5'd5, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "no_match");
        step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "zero_reg");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_RUN, "done_in_run");
        while (exp_ctl_q.size() > 0) begin
            e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
            else $display("[tb] %s ctl=%b", nm, o);
        end
        n_vec++;
        if (StallCnt !== 4'd2) begin n_err++; $display("FAIL lu_stallcnt2: got %0d want 2", StallCnt); end
    endtask

    task automatic test_branch();
        logic [6:0] e, o;
        string nm;
        do_reset();
        step(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, "br_over_lu");
        idle(C_RUN, "br_after");
        n_vec++;
        if ({StallCnt, FlushCnt} !== {4'd0, 4'd1}) begin
            n_err++; $display("FAIL br_counts: stall/flush got %0d/%0d want 0/1", StallCnt, FlushCnt);
        end
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, "br_over_mdu");
        idle(C_RUN, "br_mdu_after");
        while (exp_ctl_q.size() > 0) begin
            e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
            else $display("[tb] %s ctl=%b", nm, o);
        end
        n_vec++;
        if (FlushCnt !== 4'd2) begin n_err++; $display("FAIL br_flushcnt2: got %0d want 2", FlushCnt); end
    endtask

    task automatic test_mdu_done();
        logic [6:0] e, o;
        string nm;
        do_reset();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "mdu_start");
        for (int i = 0; i < 3; i++)
            step(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_BSTALL, "mdu_busy");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_REL, "mdu_release");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_RUN, "mdu_after");
        while (exp_ctl_q.size() > 0) begin
            e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
            else $display("[tb] %s ctl=%b", nm, o);
        end
        n_vec++;
        if ({MduErr, StallCnt, FlushCnt} !== {1'b0, 4'd4, 4'd0}) begin
            n_err++;
            $display("FAIL mdu_counts: err/stall/flush got %b/%0d/%0d want 0/4/0", MduErr, StallCnt, FlushCnt);
        end
    endtask

    task automatic test_timeout();
        logic [6:0] e, o;
        string nm;
        do_reset();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "tmo_start");
        for (int i = 0; i < TMO - 1; i++)
            idle(C_BSTALL, "tmo_busy");
        idle(C_REL, "tmo_release");
        idle(C_RUN, "tmo_after");
        step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, "tmo_then_lu");
        idle(C_RUN, "tmo_lu_after");
        while (exp_ctl_q.size() > 0) begin
            e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
            else $display("[tb] %s ctl=%b", nm, o);
        end
        n_vec++;
        if ({MduErr, StallCnt} !== {1'b1, 4'd9}) begin
            n_err++; $display("FAIL tmo_sticky: err/stall got %b/%0d want 1/9", MduErr, StallCnt);
        end
        do_reset();
        idle(C_RUN, "tmo_clear");
        void'(exp_ctl_q.pop_front()); void'(exp_nm_q.pop_front()); void'(obs_q.pop_front());
        e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
        n_vec++;
        if (MduErr !== 1'b0) begin n_err++; $display("FAIL tmo_err_clear: got %b want 0", MduErr); end
    endtask

    task automatic test_reset_busy();
        logic [6:0] e, o;
        string nm;
        do_reset();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, "rb_flush");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "rb_start");
        idle(C_BSTALL, "rb_busy");
        idle(C_BSTALL, "rb_busy");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN, "rb_reset");
        idle(C_RUN, "rb_after");
        while (exp_ctl_q.size() > 0) begin
            e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
            else $display("[tb] %s ctl=%b", nm, o);
        end
        n_vec++;
        if ({MduErr, StallCnt, FlushCnt} !== '0) begin
            n_err++;
            $display("FAIL rb_counts: err/stall/flush got %b/%0d/%0d want 0/0/0", MduErr, StallCnt, FlushCnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e, o;
        string nm;
        do_reset();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "b2b_start1");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_REL,   "b2b_done1");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "b2b_start2");
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_REL,   "b2b_done2");
        step(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,    "b2b_lu");
        idle(C_RUN, "b2b_after");
        while (exp_ctl_q.size() > 0) begin
            e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
            else $display("[tb] %s ctl=%b", nm, o);
        end
        n_vec++;
        if (StallCnt !== 4'd3) begin n_err++; $display("FAIL b2b_stallcnt: got %0d want 3", StallCnt); end
    endtask

    task automatic test_saturation();
        logic [6:0] e, o;
        string nm;
        do_reset();
        for (int i = 0; i < 20; i++)
            step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, "sat_lu");
        for (int i = 0; i < 18; i++)
            step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, "sat_br");
        idle(C_RUN, "sat_after");
        while (exp_ctl_q.size() > 0) begin
            e = exp_ctl_q.pop_front(); nm = exp_nm_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL %s: ctl got %b want %b", nm, o, e); end
        end
        $display("[tb] sat stall=%0d flush=%0d", StallCnt, FlushCnt);
        n_vec++;
        if ({StallCnt, FlushCnt} !== {4'd15, 4'd15}) begin
            n_err++; $display("FAIL sat_counts: stall/flush got %0d/%0d want 15/15", StallCnt, FlushCnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mdu_done();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
